spu_queued: RTL
===============

SPU_QUEUED -- requirements
Module: spu_queued

Interface
REQ-001 SHALL have parameter DEPTH, default 4: input queue entries, power of two, minimum 2.
REQ-002 SHALL have parameter ROB_W, default 4: ROB entry number width.
REQ-003 SHALL have parameter PREG_W, default 6: physical register address width.
REQ-004 SHALL have ports clk input 1 (clock) and reset input 1 (synchronous, active-high).
REQ-005 SHALL have port flush input 1: pipeline squash.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1: issue handshake.
REQ-007 SHALL have issue payload inputs: in_op 5, in_src1 32, in_src2 32, in_imm 16, in_simm 1 (trap src2 is sign-extended imm), in_cp0_addr 8, in_cache_op 5, in_phy_dest PREG_W, in_rob ROB_W.
REQ-008 SHALL have MMU ports: data_valid output 1, data_vaddr output 32, data_paddr input 32.
REQ-009 SHALL have TLB port tlb_op output 4, ordered {tlbwr, tlbwi, tlbr, tlbp}.
REQ-010 SHALL have cache ports: cache_op_valid output 1, cache_op output 5, cache_vaddr output 32, cache_paddr output 32, cache_op_ready input 1.
REQ-011 SHALL have CP0 ports: cp0_we output 1, cp0_addr output 8, cp0_wdata output 32, cp0_rdata input 32.
REQ-012 SHALL have commit ports: out_valid output 1, out_ready input 1, out_rob ROB_W, out_phy_dest PREG_W, out_rf_we 1, out_result 32, out_ex 1, out_exccode 5.

Function
REQ-013 SHALL decode in_op as: 1 MOVZ, 2 MOVN, 3 TEQ, 4 TNE, 5 TLT, 6 TGE, 7 TLTU, 8 TGEU, 9 MFC0, 10 MTC0, 11 ERET, 12 TLBP, 13 TLBR, 14 TLBWI, 15 TLBWR, 16 CACHE; any other value is a NOP completing with rf_we=0.
REQ-014 SHALL hold a FIFO of DEPTH entries: in_ready = !full; enqueue on in_valid && in_ready && !flush; enqueue while full SHALL never occur.
REQ-015 SHALL run an FSM with states IDLE, EXEC, XLAT, CWAIT, RESP; IDLE with FIFO non-empty pops the head into a working register and goes to XLAT for CACHE, otherwise to EXEC.
REQ-016 In EXEC, SHALL assert cp0_we (MTC0) or the matching tlb_op bit for exactly one cycle, sample cp0_rdata (MFC0, cp0_addr from the working register), register the result, and go to RESP.
REQ-017 SHALL compute the effective address as src1 + sign-extended imm, mod 2^32.
REQ-018 In XLAT, SHALL assert data_valid for one cycle with data_vaddr = effective address, latch data_paddr at the cycle end, and go to CWAIT.
REQ-019 In CWAIT, SHALL hold cache_op_valid=1 with stable cache_op, cache_vaddr and cache_paddr until cache_op_ready=1; cache_op SHALL be 0 whenever cache_op_valid=0; then go to RESP.
REQ-020 RESP SHALL hold out_valid=1 with stable payload until out_ready; on acceptance with a non-empty FIFO it SHALL pop directly into EXEC/XLAT, otherwise return to IDLE.
REQ-021 Latency: enqueue in cycle t into an idle empty unit SHALL pop at t+1, run EXEC at t+2 and give out_valid at t+3; each CACHE op SHALL add one cycle plus the cache_op_ready wait.
REQ-022 result SHALL be: MFC0 -> cp0_rdata; MOVZ with src2==0 -> src1; MOVN with src2!=0 -> src1; otherwise 0; out_rf_we SHALL be set only in these three cases.
REQ-023 Traps SHALL compare src1 against src2 (or sign-extended imm when simm=1), signed for TLT/TGE and unsigned for TLTU/TGEU; a taken trap SHALL give out_ex=1, out_exccode=13, out_rf_we=0.
REQ-024 cp0_wdata SHALL equal the working src2; side effects SHALL fire once per op regardless of out_ready stalls.
REQ-025 flush SHALL empty the FIFO and drop the working op without out_valid, taking effect next cycle, except in CWAIT, where cache_op_valid stays asserted until cache_op_ready and the unit then returns to IDLE without out_valid.
REQ-026 flush SHALL take priority over enqueue and over completion in the same cycle.

Reset
REQ-027 reset SHALL empty the FIFO, put the FSM in IDLE, and force in_ready=1 and out_valid, data_valid, cache_op_valid, cp0_we, tlb_op, out_rf_we, out_ex to 0, including mid-CWAIT.

Verification
REQ-028 MOVN src1=0x1234, src2=5, enqueued at t -> out_valid at t+3, out_result=0x1234, out_rf_we=1.
REQ-029 TGEU src1=0xFFFFFFFF, imm=0x0001, simm=1 -> out_ex=1, exccode=13; same op as TGE -> out_ex=0.
REQ-030 CACHE src1=0x80000000, imm=0xFFFC, cache_op_ready held low 5 cycles -> data_vaddr=0x7FFFFFFC, cache_op_valid high 5 cycles, out_valid the cycle after ready.
REQ-031 Five MTC0 ops enqueued back-to-back with DEPTH=4 and out_ready=0 -> in_ready drops once full, cp0_we pulses exactly once per processed op.
REQ-032 flush in CWAIT -> cache_op_valid held until ready, no out_valid, FIFO empty; flush in RESP -> out_valid=0 the next cycle.

Source files
------------

// File: rtl/spu_queued_if.sv
// Issue and commit handshake bundle for the queued special-purpose unit.
// The producer/consumer side uses master; the unit itself uses slave.
interface spu_queued_if #(
    parameter int ROB_W  = 4,
    parameter int PREG_W = 6
) ();
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [31:0]       in_src1;
    logic [31:0]       in_src2;
    logic [15:0]       in_imm;
    logic              in_simm;
    logic [7:0]        in_cp0_addr;
    logic [4:0]        in_cache_op;
    logic [PREG_W-1:0] in_phy_dest;
    logic [ROB_W-1:0]  in_rob;

    logic              out_valid;
    logic              out_ready;
    logic [ROB_W-1:0]  out_rob;
    logic [PREG_W-1:0] out_phy_dest;
    logic              out_rf_we;
    logic [31:0]       out_result;
    logic              out_ex;
    logic [4:0]        out_exccode;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_imm, in_simm,
               in_cp0_addr, in_cache_op, in_phy_dest, in_rob, out_ready,
        input  in_ready, out_valid, out_rob, out_phy_dest, out_rf_we,
               out_result, out_ex, out_exccode
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_imm, in_simm,
               in_cp0_addr, in_cache_op, in_phy_dest, in_rob, out_ready,
        output in_ready, out_valid, out_rob, out_phy_dest, out_rf_we,
               out_result, out_ex, out_exccode
    );
endinterface

// File: rtl/spu_queued.sv
// Queued special-purpose unit: conditional moves, traps, CP0/TLB access and
// CACHE ops, buffered by a small FIFO and sequenced by a single FSM.
module spu_queued #(
    parameter int DEPTH  = 4,
    parameter int ROB_W  = 4,
    parameter int PREG_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    spu_queued_if.slave bus,
    output logic        data_valid,
    output logic [31:0] data_vaddr,
    input  logic [31:0] data_paddr,
    output logic [3:0]  tlb_op,
    output logic        cache_op_valid,
    output logic [4:0]  cache_op,
    output logic [31:0] cache_vaddr,
    output logic [31:0] cache_paddr,
    input  logic        cache_op_ready,
    output logic        cp0_we,
    output logic [7:0]  cp0_addr,
    output logic [31:0] cp0_wdata,
    input  logic [31:0] cp0_rdata
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [4:0] OP_MOVZ  = 5'd1;
    localparam logic [4:0] OP_MOVN  = 5'd2;
    localparam logic [4:0] OP_TEQ   = 5'd3;
    localparam logic [4:0] OP_TNE   = 5'd4;
    localparam logic [4:0] OP_TLT   = 5'd5;
    localparam logic [4:0] OP_TGE   = 5'd6;
    localparam logic [4:0] OP_TLTU  = 5'd7;
    localparam logic [4:0] OP_TGEU  = 5'd8;
    localparam logic [4:0] OP_MFC0  = 5'd9;
    localparam logic [4:0] OP_MTC0  = 5'd10;
    localparam logic [4:0] OP_TLBP  = 5'd12;
    localparam logic [4:0] OP_TLBR  = 5'd13;
    localparam logic [4:0] OP_TLBWI = 5'd14;
    localparam logic [4:0] OP_TLBWR = 5'd15;
    localparam logic [4:0] OP_CACHE = 5'd16;

    localparam logic [4:0] EXC_TRAP = 5'd13;

    typedef struct packed {
        logic [4:0]        op;
        logic [31:0]       src1;
        logic [31:0]       src2;
        logic [15:0]       imm;
        logic              simm;
        logic [7:0]        cp0_addr;
        logic [4:0]        cache_op;
        logic [PREG_W-1:0] phy_dest;
        logic [ROB_W-1:0]  rob;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_XLAT,
        S_CWAIT,
        S_RESP
    } state_t;

    entry_t         fifo_q [DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    entry_t         in_entry;
    entry_t         head;

    state_t         state_q;
    state_t         state_d;
    entry_t         work_q;
    logic [31:0]    paddr_q;
    logic [31:0]    result_q;
    logic           rf_we_q;
    logic           ex_q;
    logic           flushed_q;
    logic           out_valid;

    logic [31:0]    imm_sext;
    logic [31:0]    eff_addr;
    logic [31:0]    trap_b;
    logic           eq;
    logic           lt_s;
    logic           lt_u;
    logic [31:0]    exec_result;
    logic           exec_we;
    logic           exec_ex;

    // ---------------- input FIFO ----------------
    assign in_entry = '{op:       bus.in_op,
                        src1:     bus.in_src1,
                        src2:     bus.in_src2,
                        imm:      bus.in_imm,
                        simm:     bus.in_simm,
                        cp0_addr: bus.in_cp0_addr,
                        cache_op: bus.in_cache_op,
                        phy_dest: bus.in_phy_dest,
                        rob:      bus.in_rob};

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = bus.in_valid && !full && !flush;
    assign head  = fifo_q[rd_ptr_q[AW-1:0]];

    assign bus.in_ready = !full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= in_entry;
        end
    end

    // Flush clears both pointers; push is already masked by flush.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, push};
            rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, pop};
        end
    end

    // ---------------- datapath ----------------
    assign imm_sext = {{16{work_q.imm[15]}}, work_q.imm};
    assign eff_addr = work_q.src1 + imm_sext;
    assign trap_b   = work_q.simm ? imm_sext : work_q.src2;
    assign eq       = (work_q.src1 == trap_b);
    assign lt_s     = ($signed(work_q.src1) < $signed(trap_b));
    assign lt_u     = (work_q.src1 < trap_b);

    always_comb begin
        exec_result = '0;
        exec_we     = 1'b0;
        exec_ex     = 1'b0;
        case (work_q.op)
            OP_MOVZ: begin
                if (work_q.src2 == '0) begin
                    exec_result = work_q.src1;
                    exec_we     = 1'b1;
                end
            end
            OP_MOVN: begin
                if (work_q.src2 != '0) begin
                    exec_result = work_q.src1;
                    exec_we     = 1'b1;
                end
            end
            OP_MFC0: begin
                exec_result = cp0_rdata;
                exec_we     = 1'b1;
            end
            OP_TEQ:  exec_ex = eq;
            OP_TNE:  exec_ex = !eq;
            OP_TLT:  exec_ex = lt_s;
            OP_TGE:  exec_ex = !lt_s;
            OP_TLTU: exec_ex = lt_u;
            OP_TGEU: exec_ex = !lt_u;
            default: ;
        endcase
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d        = state_q;
        pop            = 1'b0;
        data_valid     = 1'b0;
        cache_op_valid = 1'b0;
        cp0_we         = 1'b0;
        tlb_op         = '0;
        out_valid      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!flush && !empty) begin
                    pop     = 1'b1;
                    state_d = (head.op == OP_CACHE) ? S_XLAT : S_EXEC;
                end
            end
            S_EXEC: begin
                cp0_we    = (work_q.op == OP_MTC0);
                tlb_op[0] = (work_q.op == OP_TLBP);
                tlb_op[1] = (work_q.op == OP_TLBR);
                tlb_op[2] = (work_q.op == OP_TLBWI);
                tlb_op[3] = (work_q.op == OP_TLBWR);
                state_d   = flush ? S_IDLE : S_RESP;
            end
            S_XLAT: begin
                data_valid = 1'b1;
                state_d    = flush ? S_IDLE : S_CWAIT;
            end
            S_CWAIT: begin
                // The cache handshake must complete even when squashed.
                cache_op_valid = 1'b1;
                if (cache_op_ready) begin
                    state_d = (flush || flushed_q) ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                out_valid = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else if (bus.out_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = (head.op == OP_CACHE) ? S_XLAT : S_EXEC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            rf_we_q   <= 1'b0;
            ex_q      <= 1'b0;
            flushed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                result_q  <= '0;
                rf_we_q   <= 1'b0;
                ex_q      <= 1'b0;
                flushed_q <= 1'b0;
            end
            if (state_q == S_EXEC) begin
                result_q <= exec_result;
                rf_we_q  <= exec_we;
                ex_q     <= exec_ex;
            end
            if (state_q == S_CWAIT && flush) begin
                flushed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            work_q <= head;
        end
        if (state_q == S_XLAT) begin
            paddr_q <= data_paddr;
        end
    end

    // ---------------- outputs ----------------
    assign data_vaddr  = eff_addr;
    assign cache_op    = cache_op_valid ? work_q.cache_op : 5'd0;
    assign cache_vaddr = eff_addr;
    assign cache_paddr = paddr_q;
    assign cp0_addr    = work_q.cp0_addr;
    assign cp0_wdata   = work_q.src2;

    assign bus.out_valid    = out_valid;
    assign bus.out_rob      = work_q.rob;
    assign bus.out_phy_dest = work_q.phy_dest;
    assign bus.out_result   = result_q;
    assign bus.out_rf_we    = out_valid && rf_we_q;
    assign bus.out_ex       = out_valid && ex_q;
    assign bus.out_exccode  = (out_valid && ex_q) ? EXC_TRAP : 5'd0;
endmodule
